// File: rtl/fetch.sv
// Instruction fetch front end: issues word-aligned fetch requests, matches
// in-order responses to their PCs, buffers them and presents one
// instruction per cycle to decode through a registered output stage.
//
// Handshakes: a request transfers on any rising edge where imem_req_valid
// and imem_req_ready are both high; once raised, imem_req_valid stays high
// with a stable imem_req_addr until that transfer or a flush. Responses have
// no back-pressure: imem_resp_valid is a single beat, in request order.
//
// inflight counts live requests (those whose responses will be kept); drop
// counts requests outstanding from before a redirect, whose responses are
// discarded. Only live requests consume buffer credit, so the redirected
// stream starts the cycle after a flush even while drops are outstanding.

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  output logic [`ADDR_SIZE:0]  imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_resp_valid,
  input  logic [`INSTR_SIZE:0] imem_resp_data,
  output logic [`ADDR_SIZE:0]  PC_out,
  output logic [`INSTR_SIZE:0] instr_out,
  output logic                 pipeline_out_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [`ADDR_SIZE:0]  redirect_pc
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  // Drops accumulate across repeated redirects while old responses are
  // still on their way, so this counter has headroom beyond BUF_DEPTH.
  localparam int DROP_W = $clog2(4 * BUF_DEPTH + 1);

  logic [`ADDR_SIZE:0]  fetch_pc;
  logic [CNT_W-1:0]     inflight;
  logic [DROP_W-1:0]    drop;
  logic [DROP_W-1:0]    drop_sum;

  logic [`ADDR_SIZE:0]  pend_pc [BUF_DEPTH];
  logic [PTR_W-1:0]     pend_wr;
  logic [PTR_W-1:0]     pend_rd;

  logic [`ADDR_SIZE:0]  fifo_pc    [BUF_DEPTH];
  logic [`INSTR_SIZE:0] fifo_instr [BUF_DEPTH];
  logic [PTR_W-1:0]     fifo_wr;
  logic [PTR_W-1:0]     fifo_rd;
  logic [CNT_W-1:0]     fifo_count;

  logic [CNT_W:0]       used;
  logic                 req_fire;
  logic                 resp_take;
  logic                 fifo_pop;
  logic                 unused_redirect_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Request side: address straight from fetch_pc, credit = live + buffered.
  assign used           = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count);
  assign imem_req_addr  = fetch_pc;
  assign imem_req_valid = reset && !flush && (used < (CNT_W+1)'(BUF_DEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when no drops are owed and no redirect is taking place.
  assign resp_take = imem_resp_valid && (drop == '0) && !flush;
  assign fifo_pop  = !flush && !stall && (fifo_count != '0);

  // Every outstanding request is dropped on a flush; a response arriving in
  // the flush cycle itself retires one of them immediately.
  assign drop_sum = drop + DROP_W'(inflight);

  // Low address bits of a redirect are forced to zero.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Fetch PC: redirect, advance on accepted request, wraps at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      fetch_pc <= {redirect_pc[`ADDR_SIZE:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Live in-flight and drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      drop     <= '0;
    end else if (flush) begin
      inflight <= '0;
      drop     <= (imem_resp_valid && drop_sum != '0) ? drop_sum - DROP_W'(1) : drop_sum;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_take);
      if (imem_resp_valid && drop != '0) drop <= drop - DROP_W'(1);
    end
  end

  // Pending-PC queue and instruction FIFO pointers; both emptied by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_wr    <= '0;
      pend_rd    <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      pend_wr    <= '0;
      pend_rd    <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (req_fire)  pend_wr <= ptr_inc(pend_wr);
      if (resp_take) pend_rd <= ptr_inc(pend_rd);
      if (resp_take) fifo_wr <= ptr_inc(fifo_wr);
      if (fifo_pop)  fifo_rd <= ptr_inc(fifo_rd);
      fifo_count <= fifo_count + CNT_W'(resp_take) - CNT_W'(fifo_pop);
    end
  end

  // Queue storage: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (req_fire) pend_pc[pend_wr] <= fetch_pc;
    if (resp_take) begin
      fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
      fifo_instr[fifo_wr] <= imem_resp_data;
    end
  end

  // Registered decode stage: flush clears, stall holds, otherwise pop head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipeline_out_valid <= 1'b0;
      PC_out             <= '0;
      instr_out          <= '0;
    end else if (flush) begin
      pipeline_out_valid <= 1'b0;
    end else if (!stall) begin
      if (fifo_count != '0) begin
        PC_out             <= fifo_pc[fifo_rd];
        instr_out          <= fifo_instr[fifo_rd];
        pipeline_out_valid <= 1'b1;
      end else begin
        pipeline_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a behavioural in-order instruction memory with fixed
// latency, a cycle table for the main stream, and short hand sequences for
// not-ready, flush with drops, back-to-back flushes, PC wrap and async reset.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [31:0] PC_out;
  logic [31:0] instr_out;
  logic        pipeline_out_valid;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int total = 0;
  int bad   = 0;

  fetch dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req_valid     (imem_req_valid),
    .imem_req_addr      (imem_req_addr),
    .imem_req_ready     (imem_req_ready),
    .imem_resp_valid    (imem_resp_valid),
    .imem_resp_data     (imem_resp_data),
    .PC_out             (PC_out),
    .instr_out          (instr_out),
    .pipeline_out_valid (pipeline_out_valid),
    .stall              (stall),
    .flush              (flush),
    .redirect_pc        (redirect_pc)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Instruction memory model: accepts at the edge, answers L edges later.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  mreq_t m_new;
  int    cyc = 0;
  int    lat = 1;

  always @(negedge clk) begin
    if (reset && imem_req_valid && imem_req_ready) begin
      m_new.addr = imem_req_addr;
      m_new.due  = cyc + 1 + lat;
      mq.push_back(m_new);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      mq.delete();
      imem_resp_valid = 1'b0;
    end else begin
      if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
      imem_resp_valid = 1'b0;
      if (mq.size() > 0 && mq[0].due == cyc + 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
      end
    end
  end

  // Every instruction shown to decode must be the memory word at its PC.
  always @(negedge clk) begin
    if (reset && pipeline_out_valid) chk("instr_vs_pc", instr_out, mem_word(PC_out));
  end

  // Cycle vectors: inputs for one cycle and the outputs expected in it.
  typedef struct {
    logic        stall;
    logic        flush;
    logic        ready;
    logic [31:0] redir;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } row_t;

  function automatic row_t mk(input logic s, input logic f, input logic r, input logic [31:0] rd,
                              input logic rv, input logic [31:0] a, input logic ov, input logic [31:0] pc);
    row_t x;
    x.stall = s; x.flush = f; x.ready = r; x.redir = rd;
    x.exp_rv = rv; x.exp_addr = a; x.exp_ov = ov; x.exp_pc = pc;
    return x;
  endfunction

  // Called just after a rising edge; leaves just after the next one.
  task automatic apply_row(input row_t r, input string nm);
    stall          = r.stall;
    flush          = r.flush;
    imem_req_ready = r.ready;
    redirect_pc    = r.redir;
    @(negedge clk);
    chk({nm, "_req_valid"}, 32'(imem_req_valid), 32'(r.exp_rv));
    chk({nm, "_req_addr"}, imem_req_addr, r.exp_addr);
    chk({nm, "_out_valid"}, 32'(pipeline_out_valid), 32'(r.exp_ov));
    if (r.exp_ov) chk({nm, "_pc_out"}, PC_out, r.exp_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic hrow(input logic s, input logic f, input logic r, input logic [31:0] rd,
                      input logic rv, input logic [31:0] a, input logic ov, input logic [31:0] pc,
                      input string nm);
    apply_row(mk(s, f, r, rd, rv, a, ov, pc), nm);
  endtask

  task automatic do_reset(input int l);
    reset          = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_pc    = 32'h0;
    lat            = l;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(pipeline_out_valid), 32'h0);
    chk("rst_pc_out", PC_out, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    reset = 1'b1;
  endtask

  row_t tab[18];

  initial begin
    // stall flush ready redir | req_valid req_addr out_valid pc_out
    tab[0]  = mk(0, 0, 1, 32'h0,   1, 32'h000, 0, 32'h0);
    tab[1]  = mk(0, 0, 1, 32'h0,   1, 32'h004, 0, 32'h0);
    tab[2]  = mk(0, 0, 1, 32'h0,   0, 32'h008, 0, 32'h0);
    tab[3]  = mk(0, 0, 1, 32'h0,   1, 32'h008, 1, 32'h000);
    tab[4]  = mk(0, 0, 1, 32'h0,   1, 32'h00C, 1, 32'h004);
    tab[5]  = mk(0, 0, 1, 32'h0,   0, 32'h010, 0, 32'h0);
    tab[6]  = mk(0, 0, 1, 32'h0,   1, 32'h010, 1, 32'h008);
    tab[7]  = mk(1, 0, 1, 32'h0,   1, 32'h014, 1, 32'h00C);
    tab[8]  = mk(1, 0, 1, 32'h0,   0, 32'h018, 1, 32'h00C);
    tab[9]  = mk(1, 0, 1, 32'h0,   0, 32'h018, 1, 32'h00C);
    tab[10] = mk(1, 0, 1, 32'h0,   0, 32'h018, 1, 32'h00C);
    tab[11] = mk(0, 0, 1, 32'h0,   0, 32'h018, 1, 32'h00C);
    tab[12] = mk(0, 0, 1, 32'h0,   1, 32'h018, 1, 32'h010);
    tab[13] = mk(1, 1, 1, 32'h203, 0, 32'h01C, 1, 32'h014);
    tab[14] = mk(0, 0, 1, 32'h0,   1, 32'h200, 0, 32'h0);
    tab[15] = mk(0, 0, 1, 32'h0,   1, 32'h204, 0, 32'h0);
    tab[16] = mk(0, 0, 1, 32'h0,   0, 32'h208, 0, 32'h0);
    tab[17] = mk(0, 0, 1, 32'h0,   1, 32'h208, 1, 32'h200);

    // Main stream, 1-cycle memory, with a stall window and flush+stall.
    do_reset(1);
    for (int i = 0; i < 18; i++) apply_row(tab[i], $sformatf("t%0d", i));

    // Asynchronous reset away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_req_valid", 32'(imem_req_valid), 32'h0);
    chk("async_out_valid", 32'(pipeline_out_valid), 32'h0);
    chk("async_pc_out", PC_out, 32'h0);
    chk("async_instr_out", instr_out, 32'h0);

    // Not ready for 3 cycles, then a redirect to the top word and wrap.
    do_reset(1);
    hrow(0, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0, "nr0");
    hrow(0, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0, "nr1");
    hrow(0, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0, "nr2");
    hrow(0, 0, 1, 32'h0,          1, 32'h0000_0000, 0, 32'h0, "nr3");
    hrow(0, 1, 1, 32'hFFFF_FFFE,  0, 32'h0000_0004, 0, 32'h0, "wrap_flush");
    hrow(0, 0, 1, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0, "wrap_c5");
    hrow(0, 0, 1, 32'h0,          1, 32'h0000_0000, 0, 32'h0, "wrap_c6");
    hrow(0, 0, 1, 32'h0,          0, 32'h0000_0004, 0, 32'h0, "wrap_c7");
    hrow(0, 0, 1, 32'h0,          1, 32'h0000_0004, 1, 32'hFFFF_FFFC, "wrap_c8");
    hrow(0, 0, 1, 32'h0,          1, 32'h0000_0008, 1, 32'h0000_0000, "wrap_c9");

    // Flush with two requests in flight, 3-cycle memory.
    do_reset(3);
    hrow(0, 0, 1, 32'h0,   1, 32'h000, 0, 32'h0, "fl_c0");
    hrow(0, 0, 1, 32'h0,   1, 32'h004, 0, 32'h0, "fl_c1");
    hrow(0, 1, 1, 32'h100, 0, 32'h008, 0, 32'h0, "fl_c2");
    hrow(0, 0, 1, 32'h0,   1, 32'h100, 0, 32'h0, "fl_c3");
    hrow(0, 0, 1, 32'h0,   1, 32'h104, 0, 32'h0, "fl_c4");
    hrow(0, 0, 1, 32'h0,   0, 32'h108, 0, 32'h0, "fl_c5");
    hrow(0, 0, 1, 32'h0,   0, 32'h108, 0, 32'h0, "fl_c6");
    hrow(0, 0, 1, 32'h0,   0, 32'h108, 0, 32'h0, "fl_c7");
    hrow(0, 0, 1, 32'h0,   1, 32'h108, 1, 32'h100, "fl_c8");

    // Back-to-back flushes: drops accumulate, last redirect wins.
    do_reset(3);
    hrow(0, 0, 1, 32'h0,   1, 32'h000, 0, 32'h0, "bb_c0");
    hrow(0, 0, 1, 32'h0,   1, 32'h004, 0, 32'h0, "bb_c1");
    hrow(0, 1, 1, 32'h100, 0, 32'h008, 0, 32'h0, "bb_c2");
    hrow(0, 1, 1, 32'h300, 0, 32'h100, 0, 32'h0, "bb_c3");
    hrow(0, 0, 1, 32'h0,   1, 32'h300, 0, 32'h0, "bb_c4");
    hrow(0, 0, 1, 32'h0,   1, 32'h304, 0, 32'h0, "bb_c5");
    hrow(0, 0, 1, 32'h0,   0, 32'h308, 0, 32'h0, "bb_c6");
    hrow(0, 0, 1, 32'h0,   0, 32'h308, 0, 32'h0, "bb_c7");
    hrow(0, 0, 1, 32'h0,   0, 32'h308, 0, 32'h0, "bb_c8");
    hrow(0, 0, 1, 32'h0,   1, 32'h308, 1, 32'h300, "bb_c9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
